// File: rtl/harq_llr_combiner.sv
// HARQ soft-combiner: pulls RDM words, adds them to the HARQ circular buffer with
// per-LLR saturation and writes the result back; first transmissions bypass the add.
module harq_llr_combiner #(
    parameter int LLR_W   = 6,
    parameter int LLR_NUM = 16,
    parameter int ADDR_W  = 16
) (
    input  logic                     i_core_clk,
    input  logic                     i_rx_rstn,
    input  logic                     i_rx_fsm_rstn,
    input  logic                     i_Combine_process_request,
    input  logic [13:0]              i_Current_Combine_E01_Size,
    input  logic [ADDR_W-1:0]        i_Current_Combine_Ncb_Size,
    input  logic [ADDR_W-1:0]        i_Combine_Start_Word,
    input  logic                     i_First_Transmission,
    output logic                     o_RDM_Data_Request,
    input  logic                     i_RDM_Data_Valid,
    input  logic                     i_RDM_Data_Comp,
    input  logic [LLR_W*LLR_NUM-1:0] i_RDM_Data_Content,
    output logic                     o_harq_rd_en,
    output logic [ADDR_W-1:0]        o_harq_rd_addr,
    input  logic [LLR_W*LLR_NUM-1:0] i_harq_rd_data,
    output logic                     o_harq_wr_en,
    output logic [ADDR_W-1:0]        o_harq_wr_addr,
    output logic [LLR_W*LLR_NUM-1:0] o_harq_wr_data,
    output logic                     o_combine_busy,
    output logic                     o_combine_done,
    output logic                     o_combine_err
);

    localparam int DATA_W = LLR_W * LLR_NUM;
    localparam logic signed [LLR_W:0] SAT_MAX = (LLR_W+1)'((1 << (LLR_W-1)) - 1);
    localparam logic signed [LLR_W:0] SAT_MIN = -SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [13:0]         e01_q;
    logic [13:0]         cnt_q;
    logic [ADDR_W-1:0]   ncb_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                first_q;

    logic [13:0]         cnt_nxt;
    logic [ADDR_W-1:0]   addr_inc;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                last_word;
    logic                accept;

    // Combine stage (one cycle after the RDM word is accepted)
    logic                s1_valid;
    logic [ADDR_W-1:0]   s1_addr;
    logic [DATA_W-1:0]   s1_rdm;
    logic                s1_first;
    logic                s1_fwd;
    logic [DATA_W-1:0]   s1_fwd_data;

    logic [DATA_W-1:0]   harq_op;
    logic [DATA_W-1:0]   comb_data;
    logic [DATA_W-1:0]   wr_data_nxt;
    logic signed [LLR_W:0] llr_a;
    logic signed [LLR_W:0] llr_b;
    logic signed [LLR_W:0] llr_sum;

    assign cnt_nxt   = cnt_q + 14'd1;
    assign last_word = (cnt_nxt == e01_q);
    assign addr_inc  = addr_q + ADDR_W'(1);
    assign addr_nxt  = (addr_inc == ncb_q) ? '0 : addr_inc;
    assign accept    = (state_q == S_WAIT) && i_RDM_Data_Valid && i_rx_fsm_rstn;

    assign o_harq_rd_en   = accept && !first_q;
    assign o_harq_rd_addr = addr_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        comb_data = '0;
        llr_a     = '0;
        llr_b     = '0;
        llr_sum   = '0;
        harq_op   = s1_fwd ? s1_fwd_data : i_harq_rd_data;
        for (int n = 0; n < LLR_NUM; n++) begin
            llr_a   = {s1_rdm[n*LLR_W+LLR_W-1], s1_rdm[n*LLR_W +: LLR_W]};
            llr_b   = {harq_op[n*LLR_W+LLR_W-1], harq_op[n*LLR_W +: LLR_W]};
            llr_sum = llr_a + llr_b;
            if (llr_sum > SAT_MAX) begin
                llr_sum = SAT_MAX;
            end else if (llr_sum < SAT_MIN) begin
                llr_sum = SAT_MIN;
            end
            comb_data[n*LLR_W +: LLR_W] = llr_sum[LLR_W-1:0];
        end
        wr_data_nxt = s1_first ? s1_rdm : comb_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q            <= S_IDLE;
            e01_q              <= '0;
            cnt_q              <= '0;
            ncb_q              <= '0;
            addr_q             <= '0;
            first_q            <= 1'b0;
            o_RDM_Data_Request <= 1'b0;
            o_combine_busy     <= 1'b0;
            o_combine_done     <= 1'b0;
            o_combine_err      <= 1'b0;
        end else if (!i_rx_fsm_rstn) begin
            state_q            <= S_IDLE;
            cnt_q              <= '0;
            addr_q             <= '0;
            o_RDM_Data_Request <= 1'b0;
            o_combine_busy     <= 1'b0;
            o_combine_done     <= 1'b0;
            o_combine_err      <= 1'b0;
        end else begin
            o_RDM_Data_Request <= 1'b0;
            o_combine_done     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_Combine_process_request) begin
                        e01_q          <= i_Current_Combine_E01_Size;
                        ncb_q          <= i_Current_Combine_Ncb_Size;
                        addr_q         <= i_Combine_Start_Word;
                        first_q        <= i_First_Transmission;
                        cnt_q          <= '0;
                        o_combine_err  <= 1'b0;
                        o_combine_busy <= 1'b1;
                        if (i_Current_Combine_E01_Size == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q            <= S_REQ;
                            o_RDM_Data_Request <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_RDM_Data_Valid) begin
                        cnt_q  <= cnt_nxt;
                        addr_q <= addr_nxt;
                        // Comp must coincide exactly with the last counted word
                        if (i_RDM_Data_Comp != last_word) begin
                            o_combine_err <= 1'b1;
                        end
                        if (last_word) begin
                            state_q <= S_DRAIN;
                        end else begin
                            state_q            <= S_REQ;
                            o_RDM_Data_Request <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (o_harq_wr_en) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_combine_done <= 1'b1;
                    o_combine_busy <= 1'b0;
                    state_q        <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: the datapath registers are reset as well so every output reads 0 out of reset.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            s1_valid       <= 1'b0;
            s1_addr        <= '0;
            s1_rdm         <= '0;
            s1_first       <= 1'b0;
            s1_fwd         <= 1'b0;
            s1_fwd_data    <= '0;
            o_harq_wr_en   <= 1'b0;
            o_harq_wr_addr <= '0;
            o_harq_wr_data <= '0;
        end else if (!i_rx_fsm_rstn) begin
            s1_valid     <= 1'b0;
            o_harq_wr_en <= 1'b0;
        end else begin
            s1_valid     <= accept;
            o_harq_wr_en <= s1_valid;
            if (accept) begin
                s1_addr     <= addr_q;
                s1_rdm      <= i_RDM_Data_Content;
                s1_first    <= first_q;
                // RAM read in the same cycle as a write to the same word returns stale data
                s1_fwd      <= o_harq_wr_en && (o_harq_wr_addr == addr_q);
                s1_fwd_data <= o_harq_wr_data;
            end
            if (s1_valid) begin
                o_harq_wr_addr <= s1_addr;
                o_harq_wr_data <= wr_data_nxt;
            end
        end
    end

endmodule
